key_evt: RTL and testbench
==========================

KEY_EVT -- requirements
Module: key_evt

Interface
REQ-001 Parameter HOLD_CYCLES, default 8: cycles in==1 after press before long-press event; legal range 2..2^CNT_W-1.
REQ-002 Parameter REPEAT_CYCLES, default 4: autorepeat period in cycles; legal range 2..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 16: internal counter width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in  input  1  debounced, clk-synchronous key level (1 = pressed).
REQ-007 press  output  1  one-cycle pulse on key press.
REQ-008 release  output  1  one-cycle pulse on key release.
REQ-009 long  output  1  one-cycle pulse when hold reaches HOLD_CYCLES.
REQ-010 rep  output  1  one-cycle autorepeat pulse.
REQ-011 held  output  1  level, 1 while key is in any non-IDLE state.

Function
REQ-012 FSM states SHALL be IDLE, PRESSED, HELD; all outputs SHALL be registered, 1-cycle latency from sampling edge.
REQ-013 IDLE, edge samples in==1: SHALL go PRESSED, cnt=0, press=1 in following cycle.
REQ-014 PRESSED, edge samples in==1, cnt<HOLD_CYCLES-1: cnt SHALL increment, no pulse.
REQ-015 PRESSED, edge samples in==1, cnt==HOLD_CYCLES-1: SHALL go HELD, cnt=0, long=1 for one cycle; long thus follows press by exactly HOLD_CYCLES cycles.
REQ-016 HELD, edge samples in==1: cnt SHALL increment; at cnt==REPEAT_CYCLES-1 rep=1 for one cycle and cnt=0; first rep follows long by REPEAT_CYCLES cycles, then every REPEAT_CYCLES.
REQ-017 PRESSED or HELD, edge samples in==0: SHALL go IDLE, cnt=0, release=1 for one cycle; release overrides any long/rep due at that edge.
REQ-018 IDLE, in==0: no state change, all pulses 0.
REQ-019 At most one of press/release/long/rep SHALL be 1 in any cycle.
REQ-020 cnt SHALL never wrap; parameter values outside legal range SHALL be rejected at elaboration.
REQ-021 held SHALL be 1 from the cycle press is 1 through the cycle before release is 1, inclusive.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, cnt=0, press=release=long=rep=held=0, regardless of clk.
REQ-023 Reset mid-hold SHALL discard the hold with no release pulse; if in==1 at first edge after rst deasserts, press SHALL be emitted.

Configuration
REQ-024 Macro KEY_EVT_AUTOREPEAT_EN defined: REQ-016 behaviour active.
REQ-025 Macro KEY_EVT_AUTOREPEAT_EN undefined: HELD SHALL hold cnt static, rep SHALL be constant 0, repeat logic SHALL not be synthesized; all other behaviour unchanged.

Structure
REQ-026 Package key_evt_pkg SHALL hold state enum (IDLE, PRESSED, HELD) and default HOLD_CYCLES/REPEAT_CYCLES/CNT_W constants.
REQ-027 One sub-module, evt_pulse (registered single-cycle pulse generator), SHALL be instantiated per event output; FSM and counter stay in key_evt.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=16)
REQ-028 in 0->1 after edge n, held 3 cycles, then 0 -> press after edge n, release 3 cycles later, no long/rep.
REQ-029 in held 1 for 20 cycles -> press at n, long at n+8, rep at n+12, n+16, n+20 (macro defined); rep never (macro undefined).
REQ-030 in drops to 0 at the edge where long would fire (n+8) -> release only, long never asserted.
REQ-031 rst pulsed at cycle n+5 while in==1, released at n+7 -> all outputs 0 during reset, no release, press at first edge after deassert.
REQ-032 in==1 throughout reset deassertion -> press exactly one cycle after first post-reset edge, held=1 from same cycle.
REQ-033 Random in stream, 10k cycles -> at most one pulse per cycle; press/release counts differ by at most 1.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared types and default parameter values for the key event decoder.
package key_evt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam int HOLD_CYCLES_DEF   = 8;
  localparam int REPEAT_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/evt_pulse.sv
// Registered single-cycle event pulse: the pulse appears the cycle after fire is sampled.
module evt_pulse (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  output logic pulse
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pulse <= 1'b0;
    else     pulse <= fire;
  end

endmodule

// File: rtl/key_evt.sv
// Key event decoder: press / release / long-press / autorepeat pulses plus a held level.
// Autorepeat is built only when KEY_EVT_AUTOREPEAT_EN is defined; `release` is a reserved word, so that pulse is port rel.
module key_evt
  import key_evt_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press,
  output logic rel,
  output logic long,
  output logic rep,
  output logic held
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (CNT_W < 2 || CNT_W > 31) begin : g_bad_cnt_w
    $error("key_evt: CNT_W out of range");
  end
  if (HOLD_CYCLES < 2 || longint'(HOLD_CYCLES) > CNT_MAX) begin : g_bad_hold
    $error("key_evt: HOLD_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_repeat
    $error("key_evt: REPEAT_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_fire, rel_fire, long_fire, rep_fire;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_fire = 1'b0;
    rel_fire   = 1'b0;
    long_fire  = 1'b0;
    rep_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          state_nxt  = PRESSED;
          cnt_nxt    = '0;
          press_fire = 1'b1;
        end
      end
      PRESSED: begin
        if (!in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rel_fire  = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          long_fire = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        // Release wins over a repeat falling due on the same edge.
        if (!in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rel_fire  = 1'b1;
        end else begin
`ifdef KEY_EVT_AUTOREPEAT_EN
          if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
            cnt_nxt  = '0;
            rep_fire = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`else
          cnt_nxt = cnt;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      held  <= (state_nxt != IDLE);
    end
  end

  evt_pulse u_press (.clk(clk), .rst(rst), .fire(press_fire), .pulse(press));
  evt_pulse u_rel   (.clk(clk), .rst(rst), .fire(rel_fire),   .pulse(rel));
  evt_pulse u_long  (.clk(clk), .rst(rst), .fire(long_fire),  .pulse(long));

`ifdef KEY_EVT_AUTOREPEAT_EN
  evt_pulse u_rep   (.clk(clk), .rst(rst), .fire(rep_fire),   .pulse(rep));
`else
  assign rep = 1'b0;
  logic unused_rep_fire;
  assign unused_rep_fire = rep_fire;
`endif

endmodule

// File: tb/tb_key_evt.sv
// Self-checking bench for key_evt: vector table, hand-written corner sequences, random stream vs run-length model.
module tb_key_evt;

  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic rst;
  logic in;
  logic press, rel, lng, rep, held;

  always #5 clk = ~clk;

  key_evt #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in(in),
    .press(press), .rel(rel), .long(lng), .rep(rep), .held(held)
  );

`ifdef KEY_EVT_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef struct {
    logic       i;
    logic [4:0] exp;   // {press, rel, long, rep, held}
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;    // consecutive in==1 samples since the press edge (0 = idle)
  int   n_press = 0;
  int   n_rel   = 0;

  function automatic logic [4:0] outs();
    return {press, rel, lng, rep, held};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (press,rel,long,rep,held)", name, act, exp);
    end
  endtask

  // Event rules expressed over the length of the current key-down run.
  task automatic model_step(input logic i, output logic [4:0] e);
    logic p, l, r;
    if (i) begin
      k++;
      p = (k == 1);
      l = (k == HOLD + 1);
      r = REP_EN && (k > HOLD + 1) && (((k - 1 - HOLD) % REP) == 0);
      e = {p, 1'b0, l, r, 1'b1};
    end else begin
      e = {1'b0, (k > 0), 1'b0, 1'b0, 1'b0};
      k = 0;
    end
  endtask

  task automatic step(input logic i, output logic [4:0] e);
    in = i;
    @(posedge clk);
    #1;
    model_step(i, e);
  endtask

  task automatic push(input logic i, input logic [4:0] e);
    vec_t v;
    v.i = i;
    v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [4:0] e;
    logic       val;
    int         len, cyc;

    // Short press, long-press pre-empted by release, and back-to-back taps.
    push(1'b0, 5'b00000);
    push(1'b1, 5'b10001);
    push(1'b1, 5'b00001);
    push(1'b1, 5'b00001);
    push(1'b0, 5'b01000);
    push(1'b0, 5'b00000);
    push(1'b1, 5'b10001);
    for (int j = 0; j < HOLD - 1; j++) push(1'b1, 5'b00001);
    push(1'b0, 5'b01000);
    push(1'b0, 5'b00000);
    push(1'b1, 5'b10001);
    push(1'b0, 5'b01000);
    push(1'b1, 5'b10001);
    push(1'b0, 5'b01000);

    rst = 1'b1;
    in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 5'b00000);
    rst = 1'b0;

    foreach (tbl[j]) begin
      step(tbl[j].i, e);
      check($sformatf("vec%0d", j), outs(), tbl[j].exp);
    end

    // Long hold: long at +HOLD, repeats every REP after that.
    for (int j = 0; j <= 20; j++) begin
      step(1'b1, e);
      check($sformatf("hold%0d", j), outs(),
            {(j == 0), 1'b0, (j == HOLD),
             REP_EN && (j == 12 || j == 16 || j == 20), 1'b1});
    end
    step(1'b0, e);
    check("hold_release", outs(), 5'b01000);
    step(1'b0, e);

    // Reset mid-hold with key down throughout: immediate clear, no release, fresh press.
    for (int j = 0; j < 5; j++) begin
      step(1'b1, e);
      check($sformatf("pre_rst%0d", j), outs(), {(j == 0), 3'b000, 1'b1});
    end
    rst = 1'b1;
    #1;
    check("async_rst", outs(), 5'b00000);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("in_rst%0d", j), outs(), 5'b00000);
    end
    rst = 1'b0;
    k = 0;
    step(1'b1, e);
    check("post_rst_press", outs(), 5'b10001);
    step(1'b1, e);
    check("post_rst_held", outs(), 5'b00001);
    step(1'b0, e);
    check("post_rst_rel", outs(), 5'b01000);

    // Random run lengths, long enough to reach long-press and repeats.
    val = 1'b0;
    cyc = 0;
    while (cyc < 10000) begin
      val = ~val;
      len = $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        step(val, e);
        check("rand", outs(), e);
        check("onehot", {4'b0000, ($countones({press, rel, lng, rep}) > 1)}, 5'b00000);
        if (press) n_press++;
        if (rel)   n_rel++;
        cyc++;
      end
    end
    total++;
    if ((n_press - n_rel > 1) || (n_rel - n_press > 1)) begin
      bad++;
      $display("FAIL press_rel_balance: press=%0d rel=%0d required diff<=1", n_press, n_rel);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
